// File: rtl/traffic_light_sequencer_if.sv
// -----------------------------------------------------------------------------
// traffic_light_sequencer_if
//   Bundles the board-facing signals of the traffic light sequencer.
//   button : pedestrian push-button, active-high, asynchronous to clk
//   led    : light bank [0] main red, [1] main yellow, [2] main green,
//            [3] side red, [4] side yellow, [5] side green, [6] WALK,
//            [7] request pending
//   master : the board/environment side (drives button, observes led)
//   slave  : the sequencer side (samples button, drives led)
// -----------------------------------------------------------------------------
interface traffic_light_sequencer_if;
    logic       button;
    logic [7:0] led;

    modport master (output button, input led);
    modport slave  (input button, output led);
endinterface

// File: rtl/traffic_light_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_light_sequencer
//   Phase controller for a two-way intersection (main/side road) with a
//   pedestrian request. Every phase is timed in ticks of a clk prescaler;
//   the push-button is synchronised, edge-detected and latched as ped_req.
//
//   Ports
//     clk    in   rising-edge system clock
//     reset  in   asynchronous, active-high reset
//     io     slave modport of traffic_light_sequencer_if (button in, led out)
//
//   Phase order: MAIN_G -> MAIN_Y -> RED_A -> SIDE_G -> SIDE_Y -> RED_B ->
//   (WALK if a request is pending) -> MAIN_G. MAIN_G may end early on a tick
//   once T_MIN_G ticks have elapsed and a request is pending.
// -----------------------------------------------------------------------------
module traffic_light_sequencer #(
    parameter int unsigned CLK_DIV  = 100_000_000,
    parameter int unsigned T_MAIN_G = 20,
    parameter int unsigned T_MIN_G  = 5,
    parameter int unsigned T_SIDE_G = 10,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    traffic_light_sequencer_if.slave   io
);

    typedef enum logic [2:0] {
        ST_MAIN_G = 3'd0,
        ST_MAIN_Y = 3'd1,
        ST_RED_A  = 3'd2,
        ST_SIDE_G = 3'd3,
        ST_SIDE_Y = 3'd4,
        ST_RED_B  = 3'd5,
        ST_WALK   = 3'd6
    } state_t;

    // Timer value at or below which enough main-green ticks have elapsed
    // for a pedestrian request to cut the phase short.
    localparam logic [31:0] EARLY_LIMIT = T_MAIN_G - T_MIN_G + 32'd1;
    localparam logic [31:0] TICK_LAST   = CLK_DIV - 32'd1;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] presc_r;
    logic [31:0] timer_r;
    logic        sync1_r;
    logic        sync2_r;
    logic        sync3_r;
    logic        ped_req_r;
    logic        btn_rise_s;
    logic        tick_s;
    logic        expire_s;
    logic        state_change_s;
    logic        enter_walk_s;
    logic [6:0]  phase_led_s;

    // Phase duration in ticks, loaded into the timer on entry to a state.
    function automatic logic [31:0] phase_time(input state_t st);
        logic [31:0] t;
        case (st)
            ST_MAIN_G: t = T_MAIN_G;
            ST_MAIN_Y: t = T_YEL;
            ST_RED_A:  t = T_ALLRED;
            ST_SIDE_G: t = T_SIDE_G;
            ST_SIDE_Y: t = T_YEL;
            ST_RED_B:  t = T_ALLRED;
            ST_WALK:   t = T_WALK;
            default:   t = T_ALLRED;
        endcase
        return t;
    endfunction

    assign btn_rise_s     = sync2_r & ~sync3_r;
    assign tick_s         = (presc_r == TICK_LAST);
    assign expire_s       = tick_s && (timer_r == 32'd1);
    assign state_change_s = (state_next_s != state_r);
    assign enter_walk_s   = (state_next_s == ST_WALK) && (state_r != ST_WALK);

    // Two-flop synchroniser for the button plus the delayed copy used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= io.button;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RED_B;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Tick prescaler and phase timer; both restart whenever the state changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_r <= 32'd0;
            timer_r <= T_ALLRED;
        end else if (state_change_s) begin
            presc_r <= 32'd0;
            timer_r <= phase_time(state_next_s);
        end else if (tick_s) begin
            presc_r <= 32'd0;
            timer_r <= timer_r - 32'd1;
        end else begin
            presc_r <= presc_r + 32'd1;
        end
    end

    // Pedestrian request latch: clearing on WALK entry beats a same-cycle set,
    // and edges seen while already in WALK are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_req_r <= 1'b0;
        end else if (enter_walk_s) begin
            ped_req_r <= 1'b0;
        end else if (btn_rise_s && (state_r != ST_WALK)) begin
            ped_req_r <= 1'b1;
        end else begin
            ped_req_r <= ped_req_r;
        end
    end

    // Next-state logic; transitions happen only on the tick that ends a phase.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_MAIN_G: begin
                if (expire_s || (tick_s && ped_req_r && (timer_r <= EARLY_LIMIT))) begin
                    state_next_s = ST_MAIN_Y;
                end else begin
                    state_next_s = ST_MAIN_G;
                end
            end
            ST_MAIN_Y: begin
                if (expire_s) begin
                    state_next_s = ST_RED_A;
                end else begin
                    state_next_s = ST_MAIN_Y;
                end
            end
            ST_RED_A: begin
                if (expire_s) begin
                    state_next_s = ST_SIDE_G;
                end else begin
                    state_next_s = ST_RED_A;
                end
            end
            ST_SIDE_G: begin
                if (expire_s) begin
                    state_next_s = ST_SIDE_Y;
                end else begin
                    state_next_s = ST_SIDE_G;
                end
            end
            ST_SIDE_Y: begin
                if (expire_s) begin
                    state_next_s = ST_RED_B;
                end else begin
                    state_next_s = ST_SIDE_Y;
                end
            end
            ST_RED_B: begin
                if (expire_s && ped_req_r) begin
                    state_next_s = ST_WALK;
                end else if (expire_s) begin
                    state_next_s = ST_MAIN_G;
                end else begin
                    state_next_s = ST_RED_B;
                end
            end
            ST_WALK: begin
                if (expire_s) begin
                    state_next_s = ST_MAIN_G;
                end else begin
                    state_next_s = ST_WALK;
                end
            end
            default: state_next_s = ST_RED_B;
        endcase
    end

    // LED decode of the registered state; an illegal state shows all-red.
    always_comb begin
        phase_led_s = 7'h09;
        case (state_r)
            ST_MAIN_G: phase_led_s = 7'h0C;
            ST_MAIN_Y: phase_led_s = 7'h0A;
            ST_RED_A:  phase_led_s = 7'h09;
            ST_SIDE_G: phase_led_s = 7'h21;
            ST_SIDE_Y: phase_led_s = 7'h11;
            ST_RED_B:  phase_led_s = 7'h09;
            ST_WALK:   phase_led_s = 7'h49;
            default:   phase_led_s = 7'h09;
        endcase
    end

    assign io.led = {ped_req_r, phase_led_s};

endmodule
